// File: rtl/serial_add_pkg.sv
// Shared state encodings and sizing helper for the bit-serial adder controller.
package serial_add_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// Gate-level 1-bit full adder; the only arithmetic element of the serial adder.
module fa_cell (
  output logic s,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic p, g, t;

  xor x_p (p, a, b);
  xor x_s (s, p, cin);
  and a_g (g, a, b);
  and a_t (t, p, cin);
  or  o_c (cout, g, t);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry kept in a flop.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-2:0] r_sh_q, r_sh_d;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q;
  logic             fa_s, fa_c;
  logic             last_bit;

  fa_cell u_fa (
    .s    (fa_s),
    .cout (fa_c),
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q)
  );

  assign last_bit = (cnt_q == CNT_LAST);
  // Partial sum holds the low WIDTH-1 result bits; the MSB comes straight from the cell.
  assign r_sh_d   = (WIDTH-1)'({fa_s, r_sh_q} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready = (state_q == IDLE);
    done  = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        a_sh_q  <= a;
        b_sh_q  <= b;
        carry_q <= cin;
        cnt_q   <= '0;
      end else if (state_q == RUN) begin
        r_sh_q  <= r_sh_d;
        a_sh_q  <= a_sh_q >> 1;
        b_sh_q  <= b_sh_q >> 1;
        carry_q <= fa_c;
        cnt_q   <= cnt_q + 1'b1;
        // Results only move on the completing edge; carry_q is still the carry into the MSB.
        if (last_bit) begin
          sum_q  <= {fa_s, r_sh_q};
          cout_q <= fa_c;
          ovf_q  <= carry_q ^ fa_c;
        end
      end
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random stimulus for serial_add_ctrl with a queue scoreboard of expected results.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         cin = 1'b0;
  logic         ready, done, cout, overflow;
  logic [W-1:0] sum;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  res_t exp_q[$];
  res_t last_res = '0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .ready(ready), .done(done), .sum(sum), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] full;
    res_t r;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    r.s  = full[W-1:0];
    r.co = full[W];
    r.ov = (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        chk("sum", {24'd0, sum}, {24'd0, e.s});
        chk("cout", {31'd0, cout}, {31'd0, e.co});
        chk("overflow", {31'd0, overflow}, {31'd0, e.ov});
        last_res = e;
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    int guard = 0;
    while (ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_wait", {31'd0, guard < 100}, 32'd1);
    a = ta; b = tb; cin = tc; start = 1'b1;
    exp_q.push_back(model(ta, tb, tc));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain", {31'd0, exp_q.size() == 0}, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int first_done, done_cnt, ready_low, t_acc0, t_acc1;
    logic [W-1:0] ra, rb;
    logic         rc;

    // Reset state
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout_ovf", {30'd0, cout, overflow}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: latency and pulse width
    a = 8'h03; b = 8'h05; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h03, 8'h05, 1'b0));
    @(posedge clk);
    first_done = 0; done_cnt = 0; ready_low = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (first_done == 0) first_done = n;
      end
      if (ready === 1'b0) ready_low++;
    end
    chk("t1_done_cycle", first_done, W + 1);
    chk("t1_done_width", done_cnt, 1);
    chk("t1_ready_low", ready_low, W + 1);
    drain();

    // 2-4: wrap, signed overflow, all ones with carry
    do_op(8'hFF, 8'h01, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0);
    do_op(8'h80, 8'hFF, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1);
    drain();

    // 4b: start held high, operands changed after each acceptance
    start = 1'b1;
    t_acc0 = 0;
    for (int k = 0; k < 3; k++) begin
      int guard = 0;
      while (ready !== 1'b1 && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      chk("held_ready_wait", {31'd0, guard < 100}, 32'd1);
      ra = 8'h11 * (k + 1); rb = 8'h0F + k[7:0]; rc = k[0];
      a = ra; b = rb; cin = rc;
      exp_q.push_back(model(ra, rb, rc));
      t_acc1 = cyc;
      if (k > 0) chk("held_period", t_acc1 - t_acc0, W + 2);
      t_acc0 = t_acc1;
      @(negedge clk);
      a = 8'hEE; b = 8'hEE; cin = 1'b1;
    end
    start = 1'b0;
    drain();

    // 5: start during RUN is ignored, previous result held
    do_op(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5_hold_sum", {24'd0, sum}, {24'd0, last_res.s});
    chk("t5_hold_flags", {30'd0, cout, overflow}, {30'd0, last_res.co, last_res.ov});
    drain();
    chk("t5_result_kept", {24'd0, sum}, 32'h30);
    repeat (12) @(negedge clk);
    chk("t5_no_extra_op", {31'd0, ready}, 32'd1);

    // 6: reset mid-RUN
    do_op(8'h33, 8'h44, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_sum_zero", {24'd0, sum}, 32'd0);
    chk("t6_flags_zero", {30'd0, cout, overflow}, 32'd0);
    chk("t6_done_low", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("t6_ready", {31'd0, ready}, 32'd1);
    repeat (12) @(negedge clk);
    do_op(8'h01, 8'h01, 1'b0);
    drain();
    chk("t6_new_sum", {24'd0, sum}, 32'h02);

    // Random operands with random start gaps
    for (int i = 0; i < 1000; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (($urandom & 32'h7) == 0) drain();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
